// File: rtl/tx_serial_uart.sv
// 8N1 serial transmitter: one byte per partida pulse, LSB first, pronto pulse after the stop bit.
// Define TX_PARITY_EN to insert an even-parity bit after the data bits (8E1 frame).
module tx_serial_uart #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       partida,
    input  logic [7:0] dados,
    output logic       saida_serial,
    output logic       pronto,
    output logic       em_andamento
);

    // state   | meaning
    // IDLE    | line high, waiting for partida
    // START   | start bit (0) on the line
    // DATA    | data bits d0..d7, LSB first
    // PARITY  | even parity of the latched byte (TX_PARITY_EN only)
    // STOP    | stop bit (1) on the line
    // FINAL   | one-cycle pronto, line high
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_FINAL  = 3'd5
    } state_t;

    state_t          state;
    logic [TW-1:0]   tick;
    logic [3:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            bit_end;
`ifdef TX_PARITY_EN
    logic            par;
`endif

    assign bit_end = (tick == TICK_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            tick         <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            saida_serial <= 1'b1;
            pronto       <= 1'b0;
            em_andamento <= 1'b0;
`ifdef TX_PARITY_EN
            par          <= 1'b0;
`endif
        end else begin
            pronto <= 1'b0;
            tick   <= bit_end ? '0 : tick + TW'(1);
            case (state)
                // FINAL shares IDLE's start sampling so a partida held high
                // leaves exactly one idle-high cycle between frames.
                S_IDLE, S_FINAL: begin
                    tick    <= '0;
                    bit_cnt <= '0;
                    if (partida) begin
                        state        <= S_START;
                        shreg        <= dados;
                        saida_serial <= 1'b0;
                        em_andamento <= 1'b1;
`ifdef TX_PARITY_EN
                        par          <= ^dados;
`endif
                    end else begin
                        state        <= S_IDLE;
                        saida_serial <= 1'b1;
                        em_andamento <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state        <= S_DATA;
                        saida_serial <= shreg[0];
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        shreg <= {1'b0, shreg[7:1]};
                        if (bit_cnt == 4'd7) begin
`ifdef TX_PARITY_EN
                            state        <= S_PARITY;
                            saida_serial <= par;
`else
                            state        <= S_STOP;
                            saida_serial <= 1'b1;
`endif
                        end else begin
                            bit_cnt      <= bit_cnt + 4'd1;
                            saida_serial <= shreg[1];
                        end
                    end
                end
`ifdef TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        state        <= S_STOP;
                        saida_serial <= 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        state        <= S_FINAL;
                        saida_serial <= 1'b1;
                        pronto       <= 1'b1;
                        em_andamento <= 1'b0;
                    end
                end
                default: begin
                    state        <= S_IDLE;
                    tick         <= '0;
                    saida_serial <= 1'b1;
                    em_andamento <= 1'b0;
                end
            endcase
        end
    end

endmodule
